// File: rtl/vga_pong_renderer.sv
// Pixel stage behind the VGA sync generator: two-stage colour/sync pipeline plus a
// single-ball pong game whose state advances once per frame during vertical blanking.
module vga_pong_renderer #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_STEP    = 2,
  parameter int PADDLE_X     = 624,
  parameter int PADDLE_H     = 80,
  parameter int PADDLE_STEP  = 4,
  parameter int TICK_LINE    = 500,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x_loc,
  input  logic [9:0] y_loc,
  input  logic       video_on,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hs_out,
  output logic       vs_out,
  output logic [3:0] score
);
  localparam int PADDLE_W = 8;
  localparam logic [9:0] BALL_X0   = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y0   = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0] PADDLE_Y0 = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic signed [10:0] BALL_MAX_Y = 11'(SCREEN_H - BALL_SIZE);
  localparam logic signed [10:0] PAD_MAX_Y  = 11'(SCREEN_H - PADDLE_H);
  localparam logic signed [10:0] HIT_X      = 11'(PADDLE_X - BALL_SIZE);
  localparam logic signed [10:0] BSTEP      = 11'(BALL_STEP);
  localparam logic signed [10:0] PSTEP      = 11'(PADDLE_STEP);
  localparam logic signed [10:0] BSIZE      = 11'(BALL_SIZE);
  localparam logic signed [10:0] PHGT       = 11'(PADDLE_H);
  localparam logic [10:0] BSIZE_U = 11'(BALL_SIZE);
  localparam logic [10:0] PHGT_U  = 11'(PADDLE_H);
  localparam logic [10:0] PAD_X_L = 11'(PADDLE_X);
  localparam logic [10:0] PAD_X_R = 11'(PADDLE_X + PADDLE_W);

  typedef enum logic [1:0] {SERVE, PLAY, MISS} state_t;

  function automatic logic signed [10:0] sx(input logic [9:0] v);
    return signed'({1'b0, v});
  endfunction

  function automatic logic [9:0] clamp_pos(input logic signed [10:0] v,
                                           input logic signed [10:0] hi);
    if (v <= 11'sd0)    return 10'd0;
    else if (v >= hi)   return hi[9:0];
    else                return v[9:0];
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d, paddle_y_q, paddle_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  score_q, score_d;
  logic [1:0]  up_sync_q, up_sync_d, dn_sync_q, dn_sync_d;
  logic [9:0]  x_p1_q, x_p1_d, y_p1_q, y_p1_d;
  logic        vld_p1_q, vld_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
  logic [11:0] rgb_p2_q, rgb_p2_d;
  logic        hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d;

  logic              tick, up_s, dn_s, overlap, dy_n, in_ball, in_pad;
  logic signed [10:0] nx, ny, pad_n;
  logic [9:0]        ny_c;
  logic [10:0]       xe, ye, bx, by, py;

  assign tick = (x_loc == 10'd0) && (y_loc == 10'(TICK_LINE));
  assign up_s = up_sync_q[1];
  assign dn_s = dn_sync_q[1];

  always_comb begin
    up_sync_d  = {up_sync_q[0], btn_up};
    dn_sync_d  = {dn_sync_q[0], btn_down};
    state_d    = state_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    paddle_y_d = paddle_y_q;
    cnt_d      = cnt_q;
    score_d    = score_q;

    nx   = sx(ball_x_q) + (dir_x_q ? BSTEP : -BSTEP);
    ny   = sx(ball_y_q) + (dir_y_q ? BSTEP : -BSTEP);
    ny_c = clamp_pos(ny, BALL_MAX_Y);
    dy_n = dir_y_q;
    if (ny <= 11'sd0)            dy_n = 1'b1;
    else if (ny >= BALL_MAX_Y)   dy_n = 1'b0;
    // Paddle contact is judged against the ball's post-move rows and the pre-move paddle.
    overlap = (sx(ny_c) + BSIZE > sx(paddle_y_q)) && (sx(ny_c) < sx(paddle_y_q) + PHGT);
    pad_n = sx(paddle_y_q);
    if (up_s && !dn_s)      pad_n = pad_n - PSTEP;
    else if (dn_s && !up_s) pad_n = pad_n + PSTEP;

    if (tick) begin
      paddle_y_d = clamp_pos(pad_n, PAD_MAX_Y);
      case (state_q)
        SERVE: begin
          ball_x_d = BALL_X0;
          ball_y_d = BALL_Y0;
          dir_x_d  = 1'b1;
          dir_y_d  = 1'b1;
          score_d  = 4'd0;
          if (cnt_q == 8'(SERVE_FRAMES - 1)) begin
            state_d = PLAY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        PLAY: begin
          ball_y_d = ny_c;
          dir_y_d  = dy_n;
          if (nx <= 11'sd0) begin
            ball_x_d = 10'd0;
            dir_x_d  = 1'b1;
          end else if (nx >= HIT_X) begin
            if (overlap) begin
              ball_x_d = HIT_X[9:0];
              dir_x_d  = 1'b0;
              score_d  = sat_inc(score_q);
            end else begin
              // Missed: freeze the ball where it was for the MISS display.
              state_d  = MISS;
              cnt_d    = 8'd0;
              ball_y_d = ball_y_q;
              dir_y_d  = dir_y_q;
            end
          end else begin
            ball_x_d = nx[9:0];
          end
        end
        default: begin
          if (cnt_q == 8'(MISS_FRAMES - 1)) begin
            state_d  = SERVE;
            cnt_d    = 8'd0;
            ball_x_d = BALL_X0;
            ball_y_d = BALL_Y0;
            dir_x_d  = 1'b1;
            dir_y_d  = 1'b1;
            score_d  = 4'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  // Stage 1: register the incoming pixel coordinate and syncs
  always_comb begin
    x_p1_d   = x_loc;
    y_p1_d   = y_loc;
    vld_p1_d = video_on;
    hs_p1_d  = h_sync;
    vs_p1_d  = v_sync;
  end

  // Stage 2: colour lookup from stage-1 values
  always_comb begin
    xe = {1'b0, x_p1_q};
    ye = {1'b0, y_p1_q};
    bx = {1'b0, ball_x_q};
    by = {1'b0, ball_y_q};
    py = {1'b0, paddle_y_q};
    in_ball = (xe >= bx) && (xe < bx + BSIZE_U) && (ye >= by) && (ye < by + BSIZE_U);
    in_pad  = (xe >= PAD_X_L) && (xe < PAD_X_R) && (ye >= py) && (ye < py + PHGT_U);
    hs_p2_d = hs_p1_q;
    vs_p2_d = vs_p1_q;
    if (!vld_p1_q || (y_p1_q >= 10'(SCREEN_H))) rgb_p2_d = 12'h000;
    else if (in_ball)                           rgb_p2_d = 12'hFFF;
    else if (in_pad)                            rgb_p2_d = 12'h0F0;
    else if (state_q == MISS)                   rgb_p2_d = 12'hF00;
    else                                        rgb_p2_d = 12'h000;
  end

  always_ff @(posedge clk) begin
    x_p1_q <= x_p1_d;
    y_p1_q <= y_p1_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SERVE;
      ball_x_q   <= BALL_X0;
      ball_y_q   <= BALL_Y0;
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b1;
      paddle_y_q <= PADDLE_Y0;
      cnt_q      <= 8'd0;
      score_q    <= 4'd0;
      up_sync_q  <= 2'b00;
      dn_sync_q  <= 2'b00;
      vld_p1_q   <= 1'b0;
      hs_p1_q    <= 1'b1;
      vs_p1_q    <= 1'b1;
      rgb_p2_q   <= 12'h000;
      hs_p2_q    <= 1'b1;
      vs_p2_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      paddle_y_q <= paddle_y_d;
      cnt_q      <= cnt_d;
      score_q    <= score_d;
      up_sync_q  <= up_sync_d;
      dn_sync_q  <= dn_sync_d;
      vld_p1_q   <= vld_p1_d;
      hs_p1_q    <= hs_p1_d;
      vs_p1_q    <= vs_p1_d;
      rgb_p2_q   <= rgb_p2_d;
      hs_p2_q    <= hs_p2_d;
      vs_p2_q    <= vs_p2_d;
    end
  end

  assign vga_r  = rgb_p2_q[11:8];
  assign vga_g  = rgb_p2_q[7:4];
  assign vga_b  = rgb_p2_q[3:0];
  assign hs_out = hs_p2_q;
  assign vs_out = vs_p2_q;
  assign score  = score_q;
endmodule

// File: tb/tb_vga_pong_renderer.sv
// Directed bench for vga_pong_renderer: pixel-stream vector table plus frame-tick
// sequences covering serve, paddle clamping, miss, bounce and mid-rally reset.
module tb_vga_pong_renderer;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x_loc, y_loc;
  logic       video_on, h_sync, v_sync, btn_up, btn_down;
  logic [3:0] vga_r, vga_g, vga_b, score;
  logic       hs_out, vs_out;
  logic [11:0] rgb;

  int n_pass = 0;
  int n_total = 0;

  vga_pong_renderer dut (
    .clk(clk), .rst(rst), .x_loc(x_loc), .y_loc(y_loc), .video_on(video_on),
    .h_sync(h_sync), .v_sync(v_sync), .btn_up(btn_up), .btn_down(btn_down),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hs_out(hs_out), .vs_out(vs_out),
    .score(score)
  );

  always #5 clk = ~clk;
  assign rgb = {vga_r, vga_g, vga_b};

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vid;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle();
    x_loc = 10'd1; y_loc = 10'd501; video_on = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    x_loc = 10'd0; y_loc = 10'd500; video_on = 1'b0;
    @(negedge clk);
    idle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic probe(input string name, input int px, input int py, input logic [11:0] exp);
    @(negedge clk);
    x_loc = 10'(px); y_loc = 10'(py); video_on = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    chk(name, {20'd0, rgb}, {20'd0, exp});
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic setv(input int i, input int x, input int y, input logic vid,
                      input logic hs, input logic vs, input logic [11:0] c);
    vecs[i].x = 10'(x); vecs[i].y = 10'(y); vecs[i].vid = vid;
    vecs[i].hs = hs; vecs[i].vs = vs; vecs[i].rgb = c;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    setv(0,  100, 100, 1, 1, 1, 12'h000);
    setv(1,  318, 238, 1, 0, 1, 12'hFFF);
    setv(2,  318, 238, 0, 1, 0, 12'h000);
    setv(3,  316, 236, 1, 0, 0, 12'hFFF);
    setv(4,  323, 243, 1, 1, 1, 12'hFFF);
    setv(5,  324, 243, 1, 1, 0, 12'h000);
    setv(6,  315, 236, 1, 0, 1, 12'h000);
    setv(7,  316, 244, 1, 1, 1, 12'h000);
    setv(8,  628, 200, 1, 0, 1, 12'h0F0);
    setv(9,  624, 279, 1, 1, 1, 12'h0F0);
    setv(10, 631, 280, 1, 1, 0, 12'h000);
    setv(11, 632, 250, 1, 1, 1, 12'h000);
    setv(12, 623, 250, 1, 0, 0, 12'h000);
    setv(13, 639, 479, 1, 1, 1, 12'h000);
    setv(14, 628, 480, 1, 0, 1, 12'h000);

    // Reset with hostile inputs: outputs must sit at reset values.
    rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    x_loc = 10'd318; y_loc = 10'd238; video_on = 1'b1; h_sync = 1'b0; v_sync = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rgb", {20'd0, rgb}, 32'h0);
    chk("reset_syncs", {30'd0, hs_out, vs_out}, 32'h3);
    chk("reset_score", {28'd0, score}, 32'h0);
    rst = 1'b0;
    idle();

    // Vector stream: one pixel per clock, result checked two clocks later.
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i < NV) begin
        x_loc = vecs[i].x; y_loc = vecs[i].y; video_on = vecs[i].vid;
        h_sync = vecs[i].hs; v_sync = vecs[i].vs;
      end else begin
        idle();
      end
      @(posedge clk);
      #1;
      if (i >= 1)
        chk($sformatf("vec%0d", i - 1), {18'd0, rgb, hs_out, vs_out},
            {18'd0, vecs[i-1].rgb, vecs[i-1].hs, vecs[i-1].vs});
    end

    // Serve hold, then play starts.
    ticks(59);
    probe("serve_hold", 316, 236, 12'hFFF);
    tick();
    probe("play_entry", 316, 236, 12'hFFF);
    tick();
    probe("moved_old", 316, 236, 12'h000);
    probe("moved_new", 325, 245, 12'hFFF);
    probe("moved_corner", 318, 238, 12'hFFF);

    // Run to the right edge with paddle still at 200: ball at rows 408.. misses.
    ticks(148);
    probe("pre_edge_ball", 614, 410, 12'hFFF);
    probe("pre_edge_left", 613, 410, 12'h000);
    chk("score_play", {28'd0, score}, 32'h0);
    tick();
    probe("miss_bg", 100, 100, 12'hF00);
    probe("miss_frozen", 614, 410, 12'hFFF);
    probe("miss_paddle", 628, 200, 12'h0F0);
    probe("miss_offscreen", 100, 480, 12'h000);
    ticks(29);
    probe("miss_hold", 100, 100, 12'hF00);
    tick();
    probe("serve_bg", 100, 100, 12'h000);
    probe("serve_recentre", 316, 236, 12'hFFF);
    chk("serve_score", {28'd0, score}, 32'h0);

    // Paddle up to the top clamp, then both buttons hold it.
    btn_up = 1'b1;
    settle();
    ticks(55);
    probe("pad_top", 628, 0, 12'h0F0);
    probe("pad_top_end", 628, 79, 12'h0F0);
    probe("pad_below", 628, 80, 12'h000);
    btn_down = 1'b1;
    settle();
    ticks(3);
    probe("both_top", 628, 0, 12'h0F0);
    probe("both_below", 628, 80, 12'h000);
    btn_up = 1'b0;
    settle();
    ticks(2);
    probe("pad_down", 628, 8, 12'h0F0);
    probe("pad_down_above", 628, 7, 12'h000);

    // Paddle descends to bottom clamp 400 and catches the ball at rows 408..415.
    ticks(149);
    probe("pad_bot_above", 628, 399, 12'h000);
    probe("pad_bot", 628, 479, 12'h0F0);
    tick();
    chk("hit_score", {28'd0, score}, 32'h1);
    probe("hit_pos", 616, 408, 12'hFFF);
    tick();
    probe("bounce_ball", 614, 406, 12'hFFF);
    probe("bounce_left", 622, 408, 12'h000);
    chk("score_kept", {28'd0, score}, 32'h1);

    // Reset in the middle of the rally.
    @(negedge clk);
    x_loc = 10'd614; y_loc = 10'd406; video_on = 1'b1; h_sync = 1'b0; v_sync = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_reset", {18'd0, rgb, hs_out, vs_out}, {18'd0, 12'hFFF, 2'b00});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async", {14'd0, score, rgb, hs_out, vs_out}, {14'd0, 4'd0, 12'h000, 2'b11});
    repeat (3) @(negedge clk);
    chk("rst_held", {14'd0, score, rgb, hs_out, vs_out}, {14'd0, 4'd0, 12'h000, 2'b11});
    rst = 1'b0;
    @(posedge clk); #1;
    chk("refill_1", {18'd0, rgb, hs_out, vs_out}, {18'd0, 12'h000, 2'b11});
    @(posedge clk); #1;
    chk("refill_2", {18'd0, rgb, hs_out, vs_out}, {18'd0, 12'h000, 2'b00});
    btn_down = 1'b0;
    idle();
    probe("post_reset_ball", 316, 236, 12'hFFF);
    probe("post_reset_paddle", 628, 200, 12'h0F0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
